// File: rtl/store_port_arbiter.sv
// store_port_arbiter: owns the single D$ store port shared by the store buffer
// commit queue and the AMO unit. The store buffer owns the port by default; an AMO
// first blocks new commits, waits for the commit queue to drain, then issues and
// waits for its response.
module store_port_arbiter #(
    parameter int PAYLOAD_W     = 256,
    parameter int RDATA_W       = 64,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 sb_req_i,
    input  logic [PAYLOAD_W-1:0] sb_payload_i,
    output logic                 sb_gnt_o,
    input  logic                 sb_no_st_pending_i,
    output logic                 sb_stall_o,
    output logic                 block_commit_o,
    input  logic                 amo_req_i,
    input  logic [PAYLOAD_W-1:0] amo_payload_i,
    output logic                 amo_gnt_o,
    output logic                 amo_valid_o,
    output logic [RDATA_W-1:0]   amo_rdata_o,
    output logic                 mem_req_o,
    output logic [PAYLOAD_W-1:0] mem_payload_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [RDATA_W-1:0]   mem_rdata_i,
    output logic                 drain_timeout_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DRAIN     = 2'd1,
        AMO_ISSUE = 2'd2,
        AMO_RESP  = 2'd3
    } state_e;

    localparam int               CNT_W    = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

    state_e           state_reg, state_next;
    logic [CNT_W-1:0] drain_cnt_reg, drain_cnt_next;
    logic             drain_timeout_reg, drain_timeout_next;
    logic             sb_grant;

    // A grant only means something to the store buffer when it is actually requesting.
    assign sb_grant = sb_req_i & mem_gnt_i;

    // State, drain counter and sticky timeout flag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg         <= IDLE;
            drain_cnt_reg     <= '0;
            drain_timeout_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            drain_cnt_reg     <= drain_cnt_next;
            drain_timeout_reg <= drain_timeout_next;
        end
    end

    // Next-state logic and state-decoded port muxing.
    always_comb begin
        state_next     = state_reg;
        sb_gnt_o       = 1'b0;
        sb_stall_o     = 1'b0;
        block_commit_o = 1'b0;
        amo_gnt_o      = 1'b0;
        amo_valid_o    = 1'b0;
        amo_rdata_o    = '0;
        mem_req_o      = 1'b0;
        mem_payload_o  = '0;
        case (state_reg)
            IDLE: begin
                mem_req_o     = sb_req_i;
                mem_payload_o = sb_payload_i;
                sb_gnt_o      = sb_grant;
                if (amo_req_i && !flush_i) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                mem_req_o      = sb_req_i;
                mem_payload_o  = sb_payload_i;
                sb_gnt_o       = sb_grant;
                block_commit_o = 1'b1;
                // Flush wins; otherwise leave only once nothing is left in flight from the SB.
                if (flush_i) begin
                    state_next = IDLE;
                end else if (sb_no_st_pending_i && !sb_grant) begin
                    state_next = AMO_ISSUE;
                end
            end
            AMO_ISSUE: begin
                sb_stall_o     = 1'b1;
                block_commit_o = 1'b1;
                mem_req_o      = 1'b1;
                mem_payload_o  = amo_payload_i;
                amo_gnt_o      = mem_gnt_i;
                if (mem_gnt_i) begin
                    state_next = AMO_RESP;
                end
            end
            AMO_RESP: begin
                sb_stall_o     = 1'b1;
                block_commit_o = 1'b1;
                amo_valid_o    = mem_rvalid_i;
                if (mem_rvalid_i) begin
                    amo_rdata_o = mem_rdata_i;
                    state_next  = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Drain cycle counter: cleared on entry to DRAIN, saturating while draining.
    always_comb begin
        drain_cnt_next     = drain_cnt_reg;
        drain_timeout_next = drain_timeout_reg;
        if (state_reg == IDLE && state_next == DRAIN) begin
            drain_cnt_next = '0;
        end else if (state_reg == DRAIN && drain_cnt_reg != CNT_MAX) begin
            drain_cnt_next = drain_cnt_reg + CNT_W'(1);
        end
        if (state_reg == DRAIN && drain_cnt_reg >= CNT_LAST) begin
            drain_timeout_next = 1'b1;
        end
    end

    assign drain_timeout_o = drain_timeout_reg;

    // A response cannot arrive in the same cycle the AMO is being granted.
    a_no_gnt_and_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_reg == AMO_ISSUE) |-> !(mem_gnt_i && mem_rvalid_i));

    // The AMO unit holds its request until granted unless the pipeline flushes.
    a_amo_req_held: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_reg == DRAIN && !flush_i) |-> amo_req_i);

endmodule

// File: tb/tb_store_port_arbiter.sv
// Directed testbench for store_port_arbiter: SB pass-through, AMO sequencing,
// drain behind pending stores, flush handling, drain timeout and async reset.
module tb_store_port_arbiter;

    localparam int PW = 256;
    localparam int RW = 64;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          flush_i = 1'b0;
    logic          sb_req_i = 1'b0;
    logic [PW-1:0] sb_payload_i = '0;
    logic          sb_gnt_o;
    logic          sb_no_st_pending_i = 1'b0;
    logic          sb_stall_o;
    logic          block_commit_o;
    logic          amo_req_i = 1'b0;
    logic [PW-1:0] amo_payload_i = '0;
    logic          amo_gnt_o;
    logic          amo_valid_o;
    logic [RW-1:0] amo_rdata_o;
    logic          mem_req_o;
    logic [PW-1:0] mem_payload_o;
    logic          mem_gnt_i = 1'b0;
    logic          mem_rvalid_i = 1'b0;
    logic [RW-1:0] mem_rdata_i = '0;
    logic          drain_timeout_o;

    int n_checks = 0;
    int n_errors = 0;
    int gnt_cnt;

    store_port_arbiter #(
        .PAYLOAD_W    (PW),
        .RDATA_W      (RW),
        .DRAIN_TIMEOUT(4)
    ) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .flush_i           (flush_i),
        .sb_req_i          (sb_req_i),
        .sb_payload_i      (sb_payload_i),
        .sb_gnt_o          (sb_gnt_o),
        .sb_no_st_pending_i(sb_no_st_pending_i),
        .sb_stall_o        (sb_stall_o),
        .block_commit_o    (block_commit_o),
        .amo_req_i         (amo_req_i),
        .amo_payload_i     (amo_payload_i),
        .amo_gnt_o         (amo_gnt_o),
        .amo_valid_o       (amo_valid_o),
        .amo_rdata_o       (amo_rdata_o),
        .mem_req_o         (mem_req_o),
        .mem_payload_o     (mem_payload_o),
        .mem_gnt_i         (mem_gnt_i),
        .mem_rvalid_i      (mem_rvalid_i),
        .mem_rdata_i       (mem_rdata_i),
        .drain_timeout_o   (drain_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    localparam logic [PW-1:0] AMO_P = {8{32'hA5A5_0001}};
    localparam logic [PW-1:0] SB_X  = {8{32'h0BAD_CAFE}};

    initial begin
        // ---------------- reset state ----------------
        #2;
        chk("rst_mem_req", mem_req_o, 0);
        chk("rst_block", block_commit_o, 0);
        chk("rst_stall", sb_stall_o, 0);
        chk("rst_timeout", drain_timeout_o, 0);
        tick();
        tick();
        rst_ni = 1'b1;
        tick();

        // ---------------- 1: SB only, gnt always ----------------
        mem_gnt_i = 1'b1;
        gnt_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            sb_req_i     = 1'b1;
            sb_payload_i = {8{32'hC000_0000 + 32'(i)}};
            #1;
            gnt_cnt += int'(sb_gnt_o);
            chk("t1_payload", mem_payload_o, {8{32'hC000_0000 + 32'(i)}});
            chk("t1_block", block_commit_o, 0);
            tick();
        end
        sb_req_i = 1'b0;
        #1;
        chk("t1_gnt_count", 256'(gnt_cnt), 8);
        chk("t1_idle_req", mem_req_o, 0);
        chk("t1_idle_gnt", sb_gnt_o, 0);
        mem_gnt_i = 1'b0;
        tick();

        // ---------------- 2: AMO with empty commit queue ----------------
        sb_no_st_pending_i = 1'b1;
        amo_req_i          = 1'b1;
        amo_payload_i      = AMO_P;
        #1;                                   // T (IDLE)
        chk("t2_T_block", block_commit_o, 0);
        tick();                               // T+1 DRAIN
        chk("t2_T1_block", block_commit_o, 1);
        chk("t2_T1_mem_req", mem_req_o, 0);
        tick();                               // T+2 AMO_ISSUE
        mem_gnt_i = 1'b1;
        sb_req_i  = 1'b1;
        #1;
        chk("t2_T2_mem_req", mem_req_o, 1);
        chk("t2_T2_payload", mem_payload_o, AMO_P);
        chk("t2_T2_amo_gnt", amo_gnt_o, 1);
        chk("t2_T2_sb_gnt", sb_gnt_o, 0);
        chk("t2_T2_stall", sb_stall_o, 1);
        tick();                               // T+3 AMO_RESP
        mem_gnt_i = 1'b0;
        amo_req_i = 1'b0;
        #1;
        chk("t2_T3_mem_req", mem_req_o, 0);
        chk("t2_T3_amo_gnt", amo_gnt_o, 0);
        chk("t2_T3_valid", amo_valid_o, 0);
        tick();                               // T+4
        chk("t2_T4_valid", amo_valid_o, 0);
        tick();                               // T+5
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'hDEAD;
        #1;
        chk("t2_T5_valid", amo_valid_o, 1);
        chk("t2_T5_rdata", amo_rdata_o, 64'hDEAD);
        tick();                               // T+6 IDLE
        mem_rvalid_i = 1'b0;
        mem_gnt_i    = 1'b1;
        #1;
        chk("t2_T6_block", block_commit_o, 0);
        chk("t2_T6_stall", sb_stall_o, 0);
        chk("t2_T6_sb_gnt", sb_gnt_o, 1);
        chk("t2_T6_valid", amo_valid_o, 0);
        tick();
        sb_req_i  = 1'b0;
        mem_gnt_i = 1'b0;
        tick();

        // ---------------- 4a: flush in DRAIN ----------------
        sb_no_st_pending_i = 1'b0;
        amo_req_i          = 1'b1;
        tick();                               // DRAIN
        chk("t4a_block", block_commit_o, 1);
        tick();                               // still DRAIN
        flush_i = 1'b1;
        #1;
        chk("t4a_flush_mem_req", mem_req_o, 0);
        tick();                               // IDLE
        flush_i   = 1'b0;
        amo_req_i = 1'b0;
        #1;
        chk("t4a_idle_block", block_commit_o, 0);
        chk("t4a_idle_mem_req", mem_req_o, 0);
        tick();
        chk("t4a_idle2_mem_req", mem_req_o, 0);
        chk("t4a_timeout", drain_timeout_o, 0);

        // ---------------- 4b: flush in AMO_RESP ignored ----------------
        sb_no_st_pending_i = 1'b1;
        amo_req_i          = 1'b1;
        tick();                               // DRAIN
        tick();                               // AMO_ISSUE
        mem_gnt_i = 1'b1;
        #1;
        chk("t4b_amo_gnt", amo_gnt_o, 1);
        tick();                               // AMO_RESP
        mem_gnt_i = 1'b0;
        amo_req_i = 1'b0;
        flush_i   = 1'b1;
        #1;
        chk("t4b_resp_stall", sb_stall_o, 1);
        tick();                               // still AMO_RESP
        flush_i      = 1'b0;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'h1234_5678_9ABC_DEF0;
        #1;
        chk("t4b_block", block_commit_o, 1);
        chk("t4b_valid", amo_valid_o, 1);
        chk("t4b_rdata", amo_rdata_o, 64'h1234_5678_9ABC_DEF0);
        tick();                               // IDLE
        mem_rvalid_i = 1'b0;
        #1;
        chk("t4b_idle_stall", sb_stall_o, 0);
        chk("t4b_idle_block", block_commit_o, 0);

        // ---------------- 3: AMO behind 3 committed stores ----------------
        sb_no_st_pending_i = 1'b0;
        amo_req_i          = 1'b1;
        sb_req_i           = 1'b1;
        sb_payload_i       = {8{32'h5100_0000}};
        mem_gnt_i          = 1'b0;
        #1;                                   // T (IDLE)
        chk("t3_T_block", block_commit_o, 0);
        chk("t3_T_sb_gnt", sb_gnt_o, 0);
        tick();                               // T+1 DRAIN
        mem_gnt_i = 1'b1;
        #1;
        chk("t3_T1_block", block_commit_o, 1);
        chk("t3_T1_sb_gnt", sb_gnt_o, 1);
        chk("t3_T1_payload", mem_payload_o, {8{32'h5100_0000}});
        tick();                               // T+2
        sb_payload_i = {8{32'h5100_0001}};
        mem_gnt_i    = 1'b0;
        #1;
        chk("t3_T2_sb_gnt", sb_gnt_o, 0);
        chk("t3_T2_amo_gnt", amo_gnt_o, 0);
        tick();                               // T+3
        mem_gnt_i = 1'b1;
        #1;
        chk("t3_T3_sb_gnt", sb_gnt_o, 1);
        tick();                               // T+4
        sb_payload_i = {8{32'h5100_0002}};
        mem_gnt_i    = 1'b0;
        tick();                               // T+5
        mem_gnt_i = 1'b1;
        #1;
        chk("t3_T5_sb_gnt", sb_gnt_o, 1);
        chk("t3_T5_payload", mem_payload_o, {8{32'h5100_0002}});
        tick();                               // T+6 DRAIN, queue now empty
        sb_req_i           = 1'b0;
        sb_no_st_pending_i = 1'b1;
        mem_gnt_i          = 1'b0;
        #1;
        chk("t3_T6_mem_req", mem_req_o, 0);
        chk("t3_T6_block", block_commit_o, 1);
        tick();                               // T+7 AMO_ISSUE
        mem_gnt_i = 1'b1;
        #1;
        chk("t3_T7_payload", mem_payload_o, AMO_P);
        chk("t3_T7_amo_gnt", amo_gnt_o, 1);
        tick();                               // AMO_RESP
        mem_gnt_i = 1'b0;
        amo_req_i = 1'b0;

        // ---------------- 6: reset in AMO_RESP ----------------
        #1;
        chk("t6_pre_stall", sb_stall_o, 1);
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 64'hFFFF_FFFF;
        rst_ni       = 1'b0;
        #1;
        chk("t6_rst_stall", sb_stall_o, 0);
        chk("t6_rst_block", block_commit_o, 0);
        chk("t6_rst_valid", amo_valid_o, 0);
        chk("t6_rst_rdata", amo_rdata_o, 0);
        chk("t6_rst_timeout", drain_timeout_o, 0);
        tick();
        mem_rvalid_i = 1'b0;
        rst_ni       = 1'b1;
        tick();
        sb_req_i     = 1'b1;
        sb_payload_i = SB_X;
        mem_gnt_i    = 1'b1;
        #1;
        chk("t6_post_mem_req", mem_req_o, 1);
        chk("t6_post_sb_gnt", sb_gnt_o, 1);
        chk("t6_post_payload", mem_payload_o, SB_X);
        tick();
        sb_req_i  = 1'b0;
        mem_gnt_i = 1'b0;
        tick();

        // ---------------- 5: drain timeout ----------------
        sb_no_st_pending_i = 1'b0;
        amo_req_i          = 1'b1;
        tick();                               // DRAIN cycle 1
        for (int i = 1; i <= 6; i++) begin
            if (i == 2) chk("t5_timeout_early", drain_timeout_o, 0);
            tick();
        end
        chk("t5_timeout_set", drain_timeout_o, 1);
        flush_i = 1'b1;
        tick();                               // IDLE
        flush_i   = 1'b0;
        amo_req_i = 1'b0;
        #1;
        chk("t5_idle_block", block_commit_o, 0);
        chk("t5_timeout_sticky", drain_timeout_o, 1);
        tick();
        chk("t5_timeout_sticky2", drain_timeout_o, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
